pe_result_drain: RTL and testbench
==================================

# pe_result_drain

Result de-skew and write-back stage directly downstream of the PE array. Captures the skewed (parallelogram) result stream, realigns it into a rectangular num×num matrix, optionally transposes it, and drains it row by row to the output buffer over a valid/ready handshake. It throttles the PE array with `res_ready` while draining and raises a one-cycle `done` when the last row is accepted.

## Interface
- `num`, 4: PE array dimension; matrix is num×num, num ≥ 2
- `DW`, 32: element width, signed
- `clk` input 1: clock, all logic on rising edge
- `reset` input 1: synchronous, active-low reset
- `res_valid` input 1: PE array presents a result beat
- `res_ready` output 1: block accepts a beat this cycle
- `result[num-1:0]` input DW each, signed: skewed result lanes from the PE array
- `transpose` input 1: sampled on the first accepted beat; 1 = emit columns as rows
- `out_valid` output 1: `out_row` holds a valid row
- `out_ready` input 1: output buffer accepts the row
- `out_row[num-1:0]` output DW each, signed: one output matrix row, element j on lane j
- `out_idx` output $clog2(num): index of the row on `out_row`
- `busy` output 1: state is not IDLE
- `done` output 1: one-cycle pulse after the last row handshake
- `overflow` output 1: sticky error flag

## Operation
- States: IDLE, CAPTURE, DRAIN.
- Beat accepted when `res_valid && res_ready`. `res_ready` = 1 in IDLE and CAPTURE, 0 in DRAIN.
- Beat counter b runs 0..2num-2 and advances only on accepted beats. Gaps in `res_valid` hold the counter and the matrix.
- Skew convention: at beat b, lane k carries element C[b-k][k]. It is written to mat[b-k][k] only when 0 ≤ b-k ≤ num-1. Other lanes are ignored.
- IDLE → CAPTURE on an accepted beat, which is beat 0. `transpose` is latched on this beat.
- CAPTURE → DRAIN on acceptance of beat 2num-2. The counter clears.
- DRAIN: row counter r starts at 0.
  - `out_row[j]` = mat[r][j], or mat[j][r] if the transpose latch is set. `out_idx` = r.
  - r increments on `out_valid && out_ready`.
  - The handshake on r = num-1 returns the block to IDLE and pulses `done`.
- Data is passed through bit-exact; no arithmetic or saturation.
- `out_row` holds stable while `out_valid && !out_ready`.
- `res_valid` high in DRAIN: the beat is not accepted and `overflow` sets. `overflow` clears only on reset.
- The matrix is not cleared between jobs. Every element is overwritten in each CAPTURE.

## Timing
- Reset values, applied when `reset`=0 at an edge: state IDLE, counters 0, `out_valid`=0, `busy`=0, `done`=0, `overflow`=0, `out_idx`=0, `out_row` all 0, transpose latch 0.
- `res_ready`=1 after reset.
- Reset has priority over all other activity, including mid-CAPTURE and mid-DRAIN. A partial job is discarded and no `done` is produced.
- Minimum capture time: 2num-1 cycles with `res_valid` continuously high.
- `out_valid` rises in the cycle after beat 2num-2 is accepted. That is 1 cycle of latency from the last beat to the first row.
- With `out_ready` tied high, rows 0..num-1 appear on consecutive cycles.
- `done` is asserted in the cycle after the row num-1 handshake. In that same cycle `out_valid`=0, `busy`=0 and `res_ready`=1.
- A new beat 0 is accepted in the same cycle `done` is high. Back-to-back jobs therefore lose no cycles.
- Minimum job period: 2num-1 capture beats plus num drain cycles.

## Test plan
All cases use num=4 with C[i][j] = 10i+j fed on the skew convention, so lane k at beat b carries 10(b-k)+k when valid.
- **Basic:** 7 contiguous beats, `transpose`=0, `out_ready`=1.
  - Required rows in order: {0,1,2,3}, {10,11,12,13}, {20,21,22,23}, {30,31,32,33}, with `out_idx` 0..3.
  - `out_valid` rises 1 cycle after beat 6. `done` pulses 4 cycles later.
- **Transpose:** same stream with `transpose`=1 on beat 0.
  - Required rows: {0,10,20,30}, {1,11,21,31}, {2,12,22,32}, {3,13,23,33}.
  - A `transpose` toggle after beat 0 has no effect.
- **Input gaps and backpressure:** `res_valid` deasserted for 2 cycles after beats 1 and 4; `out_ready` alternating 0/1.
  - Required: same rows as Basic.
  - Each row is held stable until its handshake; no row is duplicated or skipped.
- **Overflow:** assert `res_valid` during DRAIN.
  - Required: `res_ready`=0, `overflow`=1 and stays 1; drained data is unchanged.
  - `overflow` returns to 0 only after reset.
- **Reset mid-operation:**
  - Pull `reset` low after beat 3: next cycle IDLE, `busy`=0, `res_ready`=1, no `done`.
  - Pull `reset` low after the row 1 handshake: `out_valid`=0 next cycle.
  - A fresh job then yields exactly the Basic rows.
- **Back-to-back jobs:** start a second job (C' = C+100) with beat 0 in the `done` cycle.
  - Required: second job accepted with no lost cycle; rows {100,101,102,103}…{130,131,132,133}.

Source files
------------

// File: rtl/pe_result_drain.sv
// Result de-skew and write-back stage: captures the parallelogram result stream from the
// PE array into a num x num matrix, then drains it row by row (optionally transposed).
module pe_result_drain #(
    parameter int unsigned num = 4,
    parameter int unsigned DW  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        res_valid,
    output logic                        res_ready,
    input  logic [num-1:0][DW-1:0]      result,
    input  logic                        transpose,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [num-1:0][DW-1:0]      out_row,
    output logic [$clog2(num)-1:0]      out_idx,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow
);

    localparam int unsigned IW = $clog2(num);
    localparam int unsigned BW = $clog2(2 * num - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t                     r_state, w_state_nxt;
    logic [BW-1:0]              r_beat, w_beat_nxt;
    logic [IW-1:0]              r_row, w_row_nxt;
    logic                       r_trans, w_trans_nxt;
    logic                       r_out_valid, r_busy, r_res_ready;
    logic                       r_done, w_done_nxt;
    logic                       r_overflow, w_overflow_nxt;
    logic [num-1:0][DW-1:0]     r_out_row, w_out_row_nxt;
    logic                       w_accept, w_hs;
    logic [DW-1:0]              r_mat [num][num];

    // Next-state, counters and the registered output row
    always_comb begin
        w_state_nxt    = r_state;
        w_beat_nxt     = r_beat;
        w_row_nxt      = r_row;
        w_trans_nxt    = r_trans;
        w_done_nxt     = 1'b0;
        w_overflow_nxt = r_overflow;
        w_out_row_nxt  = '0;
        w_accept       = res_valid && (r_state != S_DRAIN);
        w_hs           = r_out_valid && out_ready;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_CAPTURE;
                    w_beat_nxt  = BW'(1);
                    w_trans_nxt = transpose;
                end
            end
            S_CAPTURE: begin
                if (w_accept) begin
                    if (r_beat == BW'(2 * num - 2)) begin
                        w_state_nxt = S_DRAIN;
                        w_beat_nxt  = '0;
                        w_row_nxt   = '0;
                    end else begin
                        w_beat_nxt = r_beat + BW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (res_valid) begin
                    w_overflow_nxt = 1'b1;
                end
                if (w_hs) begin
                    if (r_row == IW'(num - 1)) begin
                        w_state_nxt = S_IDLE;
                        w_row_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_row_nxt = r_row + IW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Row 0 never needs the element written by the final beat, so reading the
        // current matrix is safe on the CAPTURE->DRAIN edge.
        for (int j = 0; j < int'(num); j++) begin
            w_out_row_nxt[j] = r_trans ? r_mat[j][w_row_nxt] : r_mat[w_row_nxt][j];
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_beat      <= '0;
            r_row       <= '0;
            r_trans     <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_res_ready <= 1'b1;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_row   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat      <= w_beat_nxt;
            r_row       <= w_row_nxt;
            r_trans     <= w_trans_nxt;
            r_out_valid <= (w_state_nxt == S_DRAIN);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_res_ready <= (w_state_nxt != S_DRAIN);
            r_done      <= w_done_nxt;
            r_overflow  <= w_overflow_nxt;
            r_out_row   <= w_out_row_nxt;
        end
    end

    // De-skew: lane k at beat b lands in mat[b-k][k]; out-of-range lanes are dropped
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(num); i++) begin
            for (int k = 0; k < int'(num); k++) begin
                if (w_accept && (r_beat == BW'(i + k))) begin
                    r_mat[i][k] <= result[k];
                end
            end
        end
    end

    assign res_ready = r_res_ready;
    assign out_valid = r_out_valid;
    assign out_row   = r_out_row;
    assign out_idx   = r_row;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_pe_result_drain.sv
// Directed bench for pe_result_drain (num=4): C[i][j] = 10i+j+base fed on the skew pattern.
module tb_pe_result_drain;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;

    logic                   clk;
    logic                   reset;
    logic                   res_valid;
    logic                   res_ready;
    logic [N-1:0][DW-1:0]   result;
    logic                   transpose;
    logic                   out_valid;
    logic                   out_ready;
    logic [N-1:0][DW-1:0]   out_row;
    logic [1:0]             out_idx;
    logic                   busy;
    logic                   done;
    logic                   overflow;

    int n_total = 0;
    int n_bad   = 0;

    pe_result_drain #(.num(N), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .transpose (transpose),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ev(input int r, input int j, input bit tr, input int base);
        return tr ? 32'(10 * j + r + base) : 32'(10 * r + j + base);
    endfunction

    // Feed nbeats skewed beats; toggling transpose after beat 0 must have no effect
    task automatic capture(input int base, input bit tr, input bit gaps, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            res_valid = 1'b1;
            transpose = (b == 0) ? tr : !tr;
            for (int k = 0; k < int'(N); k++) begin
                if ((b - k >= 0) && (b - k <= int'(N) - 1))
                    result[k] = 32'(10 * (b - k) + k + base);
                else
                    result[k] = 32'hBAD0_0000 | 32'(b * 16 + k);
            end
            step();
            if (b < 2 * int'(N) - 2) begin
                chk($sformatf("cap_rdy_b%0d", b), 32'(res_ready), 1);
                chk($sformatf("cap_busy_b%0d", b), 32'(busy), 1);
                chk($sformatf("cap_ov_b%0d", b), 32'(out_valid), 0);
            end
            if (gaps && (b == 1 || b == 4)) begin
                res_valid = 1'b0;
                result    = '1;
                repeat (2) begin
                    step();
                    chk($sformatf("gap_ov_b%0d", b), 32'(out_valid), 0);
                end
            end
        end
        res_valid = 1'b0;
        if (nbeats == 2 * int'(N) - 1) begin
            chk("first_row_valid", 32'(out_valid), 1);
            chk("first_row_idx", 32'(out_idx), 0);
        end
    endtask

    task automatic check_row(input int r, input int base, input bit tr, input string ph);
        chk($sformatf("%s_ov_r%0d", ph, r), 32'(out_valid), 1);
        chk($sformatf("%s_idx_r%0d", ph, r), 32'(out_idx), 32'(r));
        for (int j = 0; j < int'(N); j++)
            chk($sformatf("%s_r%0d_l%0d", ph, r, j), out_row[j], ev(r, j, tr, base));
    endtask

    // Drain nrows rows; with bp each row is stalled one cycle before its handshake
    task automatic drain(input int base, input bit tr, input bit bp, input int nrows);
        for (int r = 0; r < nrows; r++) begin
            if (bp) begin
                out_ready = 1'b0;
                check_row(r, base, tr, "pre");
                step();
                check_row(r, base, tr, "hold");
            end
            out_ready = 1'b1;
            check_row(r, base, tr, "row");
            chk($sformatf("nodone_r%0d", r), 32'(done), 0);
            step();
        end
        if (nrows == int'(N)) begin
            chk("done_pulse", 32'(done), 1);
            chk("done_ov", 32'(out_valid), 0);
            chk("done_busy", 32'(busy), 0);
            chk("done_rdy", 32'(res_ready), 1);
        end
    endtask

    initial begin
        reset     = 1'b0;
        res_valid = 1'b0;
        out_ready = 1'b1;
        transpose = 1'b0;
        result    = '0;
        step();
        step();
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_idx", 32'(out_idx), 0);
        chk("rst_rdy", 32'(res_ready), 1);
        for (int j = 0; j < int'(N); j++)
            chk($sformatf("rst_row_l%0d", j), out_row[j], 0);
        reset = 1'b1;

        // Basic
        capture(0, 1'b0, 1'b0, 7);
        drain(0, 1'b0, 1'b0, 4);
        step();
        chk("done_one_cycle", 32'(done), 0);

        // Transpose
        capture(0, 1'b1, 1'b0, 7);
        drain(0, 1'b1, 1'b0, 4);
        step();

        // Input gaps and output backpressure
        capture(0, 1'b0, 1'b1, 7);
        drain(0, 1'b0, 1'b1, 4);
        step();

        // Overflow: beat offered during DRAIN is refused and flagged
        capture(0, 1'b0, 1'b0, 7);
        out_ready = 1'b0;
        res_valid = 1'b1;
        result    = '1;
        step();
        chk("ovf_rdy", 32'(res_ready), 0);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_idx", 32'(out_idx), 0);
        res_valid = 1'b0;
        step();
        chk("ovf_sticky", 32'(overflow), 1);
        drain(0, 1'b0, 1'b0, 4);
        step();
        chk("ovf_after_job", 32'(overflow), 1);
        reset = 1'b0;
        step();
        chk("ovf_cleared", 32'(overflow), 0);
        reset = 1'b1;

        // Reset during CAPTURE (stale partial data uses a different base)
        capture(50, 1'b0, 1'b0, 4);
        reset = 1'b0;
        step();
        chk("rc_busy", 32'(busy), 0);
        chk("rc_rdy", 32'(res_ready), 1);
        chk("rc_ov", 32'(out_valid), 0);
        chk("rc_done", 32'(done), 0);
        reset = 1'b1;
        step();
        chk("rc_done2", 32'(done), 0);
        chk("rc_busy2", 32'(busy), 0);

        // Reset during DRAIN after row 1 handshake
        capture(0, 1'b0, 1'b0, 7);
        drain(0, 1'b0, 1'b0, 2);
        reset = 1'b0;
        step();
        chk("rd_ov", 32'(out_valid), 0);
        chk("rd_done", 32'(done), 0);
        chk("rd_busy", 32'(busy), 0);
        reset = 1'b1;
        step();
        chk("rd_done2", 32'(done), 0);

        // Fresh job, then a second job starting in the done cycle
        capture(0, 1'b0, 1'b0, 7);
        drain(0, 1'b0, 1'b0, 4);
        capture(100, 1'b0, 1'b0, 7);
        drain(100, 1'b0, 1'b0, 4);
        step();
        chk("b2b_idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
